// File: rtl/btn_event_pkg.sv
// Shared types and elaboration helpers for the button event block.
package btn_event_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRESS1 = 3'd1,
        ST_HOLD   = 3'd2,
        ST_WAIT2  = 3'd3,
        ST_PRESS2 = 3'd4
    } btn_state_e;

    // Bits needed to hold the values 0..n-1 (at least one bit).
    function automatic int unsigned width_of(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((64'(1) << w) < 64'(n)) w++;
        return w;
    endfunction

    function automatic int unsigned ms_tick_cycles(input int unsigned clk_freq_mhz);
        return clk_freq_mhz * 1000;
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/btn_event_if.sv
// Level input and event pulse outputs of one button channel.
interface btn_event_if;
    logic sig_i;
    logic held_o;
    logic press_p;
    logic release_p;
    logic click_p;
    logic dclick_p;
    logic long_p;
    logic repeat_p;

    modport master (
        output sig_i,
        input  held_o, press_p, release_p, click_p, dclick_p, long_p, repeat_p
    );

    modport slave (
        input  sig_i,
        output held_o, press_p, release_p, click_p, dclick_p, long_p, repeat_p
    );
endinterface

// File: rtl/btn_event_ms_tick_gen.sv
// Millisecond prescaler; tick is high while the count sits at its last value.
module ms_tick_gen
    import btn_event_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);
    localparam int unsigned CYC = ms_tick_cycles(CLK_FREQ);
    localparam int unsigned PW  = width_of(CYC);
    localparam logic [PW-1:0] PMAX = PW'(CYC - 1);

    logic [PW-1:0] presc_q, presc_d;

    always_comb begin
        presc_d = presc_q + PW'(1);
        if (clr || presc_q == PMAX) presc_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) presc_q <= '0;
        else        presc_q <= presc_d;
    end

    assign tick = (presc_q == PMAX);
endmodule

// File: rtl/btn_event.sv
// Converts a clean button level into press/release/click/double-click/long/repeat pulses.
module btn_event
    import btn_event_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 100,
    parameter int unsigned LONG_MS   = 1000,
    parameter int unsigned REPEAT_MS = 200,
    parameter int unsigned DCLICK_MS = 300
) (
    input  logic        clk,
    input  logic        rst_n,
    btn_event_if.slave  bus
);
    generate
        if (CLK_FREQ == 0 || LONG_MS == 0 || REPEAT_MS == 0 || DCLICK_MS == 0) begin : g_param_err
            $error("btn_event: CLK_FREQ and all *_MS parameters must be >= 1");
        end
    endgenerate

    localparam int unsigned CW = width_of(max3(LONG_MS, REPEAT_MS, DCLICK_MS));
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_MS - 1);
    localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_MS - 1);
    localparam logic [CW-1:0] DCL_LAST  = CW'(DCLICK_MS - 1);

    btn_state_e    state_q;
    logic [CW-1:0] cnt_q;
    logic          sig_d_q;
    logic          rise, fall, edge_w, tick_raw, tick_w;

    assign rise   = bus.sig_i & ~sig_d_q;
    assign fall   = ~bus.sig_i & sig_d_q;
    assign edge_w = rise | fall;
    // An edge restarts timing, so a coincident tick is discarded.
    assign tick_w = tick_raw & ~edge_w;

    ms_tick_gen #(.CLK_FREQ(CLK_FREQ)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (edge_w),
        .tick  (tick_raw)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            sig_d_q       <= 1'b0;
            bus.held_o    <= 1'b0;
            bus.press_p   <= 1'b0;
            bus.release_p <= 1'b0;
            bus.click_p   <= 1'b0;
            bus.dclick_p  <= 1'b0;
            bus.long_p    <= 1'b0;
            bus.repeat_p  <= 1'b0;
        end else begin
            sig_d_q       <= bus.sig_i;
            bus.held_o    <= bus.sig_i;
            bus.press_p   <= 1'b0;
            bus.release_p <= 1'b0;
            bus.click_p   <= 1'b0;
            bus.dclick_p  <= 1'b0;
            bus.long_p    <= 1'b0;
            bus.repeat_p  <= 1'b0;

            if (edge_w)      cnt_q <= '0;
            else if (tick_w) cnt_q <= cnt_q + CW'(1);

            // Every state resets the count at its own threshold, so it never wraps.
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (rise) begin
                        bus.press_p <= 1'b1;
                        state_q     <= ST_PRESS1;
                    end
                end
                ST_PRESS1: begin
                    if (fall) begin
                        bus.release_p <= 1'b1;
                        state_q       <= ST_WAIT2;
                    end else if (tick_w && cnt_q == LONG_LAST) begin
                        bus.long_p <= 1'b1;
                        cnt_q      <= '0;
                        state_q    <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (fall) begin
                        bus.release_p <= 1'b1;
                        state_q       <= ST_IDLE;
                    end else if (tick_w && cnt_q == REP_LAST) begin
                        bus.repeat_p <= 1'b1;
                        cnt_q        <= '0;
                    end
                end
                ST_WAIT2: begin
                    if (rise) begin
                        bus.press_p  <= 1'b1;
                        bus.dclick_p <= 1'b1;
                        state_q      <= ST_PRESS2;
                    end else if (tick_w && cnt_q == DCL_LAST) begin
                        bus.click_p <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= ST_IDLE;
                    end
                end
                ST_PRESS2: begin
                    if (fall) begin
                        bus.release_p <= 1'b1;
                        state_q       <= ST_IDLE;
                    end else if (tick_w && cnt_q == LONG_LAST) begin
                        bus.long_p <= 1'b1;
                        cnt_q      <= '0;
                        state_q    <= ST_HOLD;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_btn_event.sv
// Scoreboard bench for btn_event: stimulus queues expected pulses, a negedge monitor consumes them.
module tb_btn_event;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    btn_event_if bif();

    btn_event #(
        .CLK_FREQ  (1),
        .LONG_MS   (3),
        .REPEAT_MS (2),
        .DCLICK_MS (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    localparam int K_PRESS = 0, K_RELEASE = 1, K_CLICK = 2, K_DCLICK = 3, K_LONG = 4, K_REPEAT = 5;

    typedef struct {
        int kind;
        int at;
    } ev_t;

    ev_t exp_q[$];

    function automatic string kname(input int k);
        case (k)
            K_PRESS:   return "press_p";
            K_RELEASE: return "release_p";
            K_CLICK:   return "click_p";
            K_DCLICK:  return "dclick_p";
            K_LONG:    return "long_p";
            K_REPEAT:  return "repeat_p";
            default:   return "none";
        endcase
    endfunction

    function automatic logic [6:0] outs();
        return {bif.held_o, bif.press_p, bif.release_p, bif.click_p,
                bif.dclick_p, bif.long_p, bif.repeat_p};
    endfunction

    task automatic expect_ev(input int k, input int at);
        exp_q.push_back('{kind: k, at: at});
    endtask

    // Advance to 1 time unit after the posedge that brings cyc to t.
    task automatic goto(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_outs(input string nm, input logic [6:0] want);
        logic [6:0] got;
        got = outs();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: outputs got %b required %b at cycle %0d", nm, got, want, cyc);
        end
    endtask

    task automatic scen_end(input string nm, input int t);
        goto(t);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected pulses missing, first %s at cycle %0d",
                     nm, exp_q.size(), kname(exp_q[0].kind), exp_q[0].at);
            exp_q.delete();
        end
    endtask

    always @(negedge clk) begin
        logic [5:0] p;
        ev_t e;
        p = {bif.repeat_p, bif.long_p, bif.dclick_p, bif.click_p, bif.release_p, bif.press_p};
        if (p[2] | p[4] | p[5]) begin
            checks++;
            if ((32'(p[2]) + 32'(p[4]) + 32'(p[5])) > 1) begin
                errors++;
                $display("FAIL exclusive: click/long/repeat got %b%b%b at cycle %0d, required at most one",
                         p[2], p[4], p[5], cyc);
            end
        end
        for (int k = 0; k < 6; k++) begin
            if (p[k]) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected: got %s at cycle %0d, required no pulse", kname(k), cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (e.kind != k || e.at != cyc) begin
                        errors++;
                        $display("FAIL event: got %s at cycle %0d, required %s at cycle %0d",
                                 kname(k), cyc, kname(e.kind), e.at);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        bif.sig_i = 1'b0;
        rst_n     = 1'b0;
        goto(3);
        check_outs("reset_idle", 7'b0);
        rst_n = 1'b1;

        // 1: async reset while pressed, press held through reset release
        b = cyc;
        goto(b + 10); bif.sig_i = 1'b1;
        goto(b + 11);
        #2;
        check_outs("pre_reset", 7'b1100000);
        rst_n = 1'b0;
        #1;
        check_outs("async_reset", 7'b0);
        goto(b + 15); rst_n = 1'b1;
        expect_ev(K_PRESS, b + 16);
        goto(b + 17);
        check_outs("held_after_reset", 7'b1000000);
        goto(b + 100); bif.sig_i = 1'b0;
        expect_ev(K_RELEASE, b + 101);
        expect_ev(K_CLICK, b + 2101);
        scen_end("reset_press", b + 2600);

        // 2: single click
        b = cyc;
        expect_ev(K_PRESS, b + 11);
        expect_ev(K_RELEASE, b + 511);
        expect_ev(K_CLICK, b + 2511);
        goto(b + 10);  bif.sig_i = 1'b1;
        goto(b + 510); bif.sig_i = 1'b0;
        scen_end("single_click", b + 3000);

        // 3: double click
        b = cyc;
        expect_ev(K_PRESS, b + 11);
        expect_ev(K_RELEASE, b + 511);
        expect_ev(K_PRESS, b + 1311);
        expect_ev(K_DCLICK, b + 1311);
        expect_ev(K_RELEASE, b + 1811);
        goto(b + 10);   bif.sig_i = 1'b1;
        goto(b + 510);  bif.sig_i = 1'b0;
        goto(b + 1310); bif.sig_i = 1'b1;
        goto(b + 1810); bif.sig_i = 1'b0;
        scen_end("double_click", b + 4500);

        // 4: long press and auto-repeat; release lands on a tick
        b = cyc;
        expect_ev(K_PRESS, b + 11);
        expect_ev(K_LONG, b + 3011);
        expect_ev(K_REPEAT, b + 5011);
        expect_ev(K_REPEAT, b + 7011);
        expect_ev(K_RELEASE, b + 8011);
        goto(b + 10);   bif.sig_i = 1'b1;
        goto(b + 1000);
        check_outs("held_high", 7'b1000000);
        goto(b + 8010); bif.sig_i = 1'b0;
        scen_end("long_repeat", b + 10500);

        // 5: window expires, later press is a fresh single press
        b = cyc;
        expect_ev(K_PRESS, b + 11);
        expect_ev(K_RELEASE, b + 511);
        expect_ev(K_CLICK, b + 2511);
        expect_ev(K_PRESS, b + 2611);
        expect_ev(K_RELEASE, b + 3111);
        expect_ev(K_CLICK, b + 5111);
        goto(b + 10);   bif.sig_i = 1'b1;
        goto(b + 510);  bif.sig_i = 1'b0;
        goto(b + 2610); bif.sig_i = 1'b1;
        goto(b + 3110); bif.sig_i = 1'b0;
        scen_end("window_expiry", b + 5600);

        // 6: reset while waiting for a second press drops the pending click
        b = cyc;
        expect_ev(K_PRESS, b + 11);
        expect_ev(K_RELEASE, b + 511);
        goto(b + 10);   bif.sig_i = 1'b1;
        goto(b + 510);  bif.sig_i = 1'b0;
        goto(b + 1510); rst_n = 1'b0;
        #1;
        check_outs("reset_wait2", 7'b0);
        goto(b + 1515); rst_n = 1'b1;
        expect_ev(K_PRESS, b + 1601);
        expect_ev(K_RELEASE, b + 1701);
        expect_ev(K_CLICK, b + 3701);
        goto(b + 1600); bif.sig_i = 1'b1;
        goto(b + 1700); bif.sig_i = 1'b0;
        scen_end("reset_in_wait2", b + 4200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
